// File: rtl/iat_stats_sched.sv
// Purpose : shared IAT window timer plus snapshot/readout controller for NUM_SRC statistics sources.
// Latency : first report beat at tick+2, last at tick+1+NUM_SRC (rpt_ready held high); busy clears at tick+2+NUM_SRC.
// Backpressure: rpt_valid/rpt_ready; a stalled beat holds all rpt_* stable, and a window tick during a drain is dropped and flagged in overrun.
//
// Ports:
//   asclk, areset      clock, asynchronous active-high reset
//   enable             window timer run enable
//   cnt_time, win_tick window count (1..WINDOW_CYCLES) and its end-of-window decode
//   src_suitable/total packed per-source counters, source i at [i*CNT_W +: CNT_W]
//   rpt_*              one beat per source, serialised from the snapshot
//   busy, overrun      controller activity and sticky dropped-window flag (overrun_clr clears)
module iat_stats_sched #(
    parameter int WINDOW_CYCLES = 160000000,
    parameter int NUM_SRC       = 4,
    parameter int CNT_W         = 32,
    localparam int IDX_W        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                     asclk,
    input  logic                     areset,
    input  logic                     enable,
    output logic [27:0]              cnt_time,
    output logic                     win_tick,
    input  logic [NUM_SRC*CNT_W-1:0] src_suitable,
    input  logic [NUM_SRC*CNT_W-1:0] src_total,
    output logic                     rpt_valid,
    input  logic                     rpt_ready,
    output logic [IDX_W-1:0]         rpt_idx,
    output logic [CNT_W-1:0]         rpt_suitable,
    output logic [CNT_W-1:0]         rpt_total,
    output logic                     rpt_last,
    output logic                     busy,
    output logic                     overrun,
    input  logic                     overrun_clr
);

    localparam logic [27:0]      WIN_END  = 28'(WINDOW_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SRC - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    state_t           r_state;
    logic [27:0]      r_cnt_time;
    logic             r_tick_held;
    logic             r_rpt_valid;
    logic [IDX_W-1:0] r_rpt_idx;
    logic             r_rpt_last;
    logic             r_busy;
    logic             r_overrun;
    logic [CNT_W-1:0] r_sh_suit [NUM_SRC];
    logic [CNT_W-1:0] r_sh_tot  [NUM_SRC];

    logic w_win_tick;
    logic w_tick_rec;
    logic w_beat_acc;

    assign w_win_tick = (r_cnt_time == WIN_END);
    // While the timer is paused on the window end, win_tick stays high; r_tick_held
    // marks those repeat cycles so the window is only acted on once.
    assign w_tick_rec = w_win_tick & ~r_tick_held;
    assign w_beat_acc = r_rpt_valid & rpt_ready;

    // Window timer: 1..WINDOW_CYCLES, wrapping to 1 so every window (including the
    // first after reset, which starts from 0) is exactly WINDOW_CYCLES long.
    always_ff @(posedge asclk or posedge areset) begin
        if (areset) begin
            r_cnt_time  <= 28'd0;
            r_tick_held <= 1'b0;
        end else begin
            r_tick_held <= w_win_tick & ~enable;
            if (enable) begin
                r_cnt_time <= w_win_tick ? 28'd1 : r_cnt_time + 28'd1;
            end
        end
    end

    // Snapshot / drain controller
    always_ff @(posedge asclk or posedge areset) begin
        if (areset) begin
            r_state     <= ST_IDLE;
            r_rpt_valid <= 1'b0;
            r_rpt_idx   <= '0;
            r_rpt_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
            for (int i = 0; i < NUM_SRC; i++) begin
                r_sh_suit[i] <= '0;
                r_sh_tot[i]  <= '0;
            end
        end else begin
            // A tick that lands while a snapshot is still in flight is dropped; set beats clear.
            if (w_tick_rec && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_tick_rec) begin
                        r_state <= ST_CAPTURE;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    // Statistics blocks publish on the tick edge, so this cycle sees the closed window.
                    for (int i = 0; i < NUM_SRC; i++) begin
                        r_sh_suit[i] <= src_suitable[i*CNT_W +: CNT_W];
                        r_sh_tot[i]  <= src_total[i*CNT_W +: CNT_W];
                    end
                    r_rpt_idx   <= '0;
                    r_rpt_last  <= (NUM_SRC == 1);
                    r_rpt_valid <= 1'b1;
                    r_state     <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (w_beat_acc) begin
                        if (r_rpt_last) begin
                            r_rpt_valid <= 1'b0;
                            r_rpt_idx   <= '0;
                            r_rpt_last  <= 1'b0;
                            r_busy      <= 1'b0;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_rpt_idx  <= r_rpt_idx + IDX_W'(1);
                            r_rpt_last <= ((r_rpt_idx + IDX_W'(1)) == IDX_LAST);
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_rpt_valid <= 1'b0;
                    r_rpt_idx   <= '0;
                    r_rpt_last  <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign cnt_time     = r_cnt_time;
    assign win_tick     = w_win_tick;
    assign rpt_valid    = r_rpt_valid;
    assign rpt_idx      = r_rpt_idx;
    assign rpt_last     = r_rpt_last;
    assign rpt_suitable = r_sh_suit[r_rpt_idx];
    assign rpt_total    = r_sh_tot[r_rpt_idx];
    assign busy         = r_busy;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_iat_stats_sched.sv
// Purpose : self-checking bench for iat_stats_sched (WINDOW_CYCLES=20, NUM_SRC=4).
// Latency : compares outputs every cycle against a transaction-level model, plus fixed-cycle literal checks.
// Backpressure: rpt_ready is driven high, toggled, stalled and randomized across the run.
module tb_iat_stats_sched;

    localparam int W  = 20;
    localparam int N  = 4;
    localparam int CW = 32;

    logic            asclk = 1'b0;
    logic            areset = 1'b1;
    logic            enable = 1'b0;
    logic [27:0]     cnt_time;
    logic            win_tick;
    logic [N*CW-1:0] src_suitable = '0;
    logic [N*CW-1:0] src_total = '0;
    logic            rpt_valid;
    logic            rpt_ready = 1'b0;
    logic [1:0]      rpt_idx;
    logic [CW-1:0]   rpt_suitable;
    logic [CW-1:0]   rpt_total;
    logic            rpt_last;
    logic            busy;
    logic            overrun;
    logic            overrun_clr = 1'b0;

    int errors = 0;
    int checks = 0;

    iat_stats_sched #(.WINDOW_CYCLES(W), .NUM_SRC(N), .CNT_W(CW)) dut (
        .asclk(asclk), .areset(areset), .enable(enable),
        .cnt_time(cnt_time), .win_tick(win_tick),
        .src_suitable(src_suitable), .src_total(src_total),
        .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_idx(rpt_idx),
        .rpt_suitable(rpt_suitable), .rpt_total(rpt_total), .rpt_last(rpt_last),
        .busy(busy), .overrun(overrun), .overrun_clr(overrun_clr)
    );

    always #5 asclk = ~asclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // e counts enabled cycles since reset; the window position follows from it directly.
    int          m_e = 0;
    bit          m_e_chg = 0;     // e advanced on the previous edge
    bit          m_busy = 0;
    bit          m_cap = 0;       // snapshot due at end of this cycle
    bit          m_ovr = 0;
    int          m_bidx = 0;
    logic [31:0] q_s[$];
    logic [31:0] q_t[$];
    int          exp_cnt;
    bit          exp_tick, m_rec, m_old_busy, m_v;

    always @(negedge asclk) begin
        if (areset) begin
            m_e = 0; m_e_chg = 0; m_busy = 0; m_cap = 0; m_ovr = 0; m_bidx = 0;
            q_s.delete(); q_t.delete();
        end
        exp_cnt  = (m_e == 0) ? 0 : ((m_e - 1) % W) + 1;
        exp_tick = (exp_cnt == W);
        m_rec    = exp_tick && m_e_chg;
        m_v      = (q_s.size() != 0);

        chk("cnt_time", 64'(cnt_time), 64'(exp_cnt));
        chk("win_tick", 64'(win_tick), 64'(exp_tick));
        chk("rpt_valid", 64'(rpt_valid), 64'(m_v));
        chk("rpt_idx", 64'(rpt_idx), 64'(m_v ? m_bidx : 0));
        chk("rpt_last", 64'(rpt_last), 64'(m_v && (m_bidx == N - 1)));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("overrun", 64'(overrun), 64'(m_ovr));
        if (m_v) begin
            chk("rpt_suitable", 64'(rpt_suitable), 64'(q_s[0]));
            chk("rpt_total", 64'(rpt_total), 64'(q_t[0]));
        end

        if (!areset) begin
            m_old_busy = m_busy;
            if (m_cap) begin
                for (int i = 0; i < N; i++) begin
                    q_s.push_back(src_suitable[i*CW +: CW]);
                    q_t.push_back(src_total[i*CW +: CW]);
                end
                m_bidx = 0;
                m_cap  = 0;
            end else if (m_v && rpt_ready) begin
                void'(q_s.pop_front());
                void'(q_t.pop_front());
                m_bidx++;
                if (q_s.size() == 0) begin
                    m_busy = 0;
                    m_bidx = 0;
                end
            end
            if (m_rec && m_old_busy) m_ovr = 1;
            else if (overrun_clr) m_ovr = 0;
            if (m_rec && !m_old_busy) begin
                m_cap  = 1;
                m_busy = 1;
            end
            m_e_chg = enable;
            if (enable) m_e++;
        end
    end

    // ---------------- stimulus ----------------
    int nb3 = 0;
    int nb4 = 0;

    task automatic step();
        @(posedge asclk);
        #1;
    endtask

    task automatic set_pat(input int ks, input int os, input int kt, input int ot);
        for (int i = 0; i < N; i++) begin
            src_suitable[i*CW +: CW] = 32'(ks * i + os);
            src_total[i*CW +: CW]    = 32'(kt * i + ot);
        end
    endtask

    task automatic rand_src();
        for (int i = 0; i < N; i++) begin
            src_suitable[i*CW +: CW] = $urandom;
            src_total[i*CW +: CW]    = $urandom;
        end
    endtask

    // Drives inputs for cycle s (counted in edges since reset release) and checks fixed points.
    task automatic drive_step(input int s);
        overrun_clr = 1'b0;
        if (s >= 42) rand_src();
        if (s == 41) set_pat(1, 'hA0, 1, 'hB0);
        if (s == 61) set_pat(1, 'hC0, 1, 'hD0);

        if (s <= 41)                  rpt_ready = 1'b1;
        else if (s <= 59)             rpt_ready = ((s - 42) % 3 == 0);
        else if (s <= 99)             rpt_ready = 1'b0;
        else if (s <= 105)            rpt_ready = 1'b1;
        else if (s <= 149)            rpt_ready = ($urandom_range(0, 3) != 0);
        else if (s <= 169)            rpt_ready = 1'b1;
        else if (s <= 180)            rpt_ready = 1'b0;
        else if (s <= 189)            rpt_ready = 1'b1;
        else                          rpt_ready = 1'b0;

        enable = !((s >= 127 && s <= 136) || (s >= 170 && s <= 174));
        if (s == 100 || s == 105 || s == 165) overrun_clr = 1'b1;

        if (s == 20) begin
            chk("s1_cnt20", 64'(cnt_time), 64'd20);
            chk("s1_tick", 64'(win_tick), 64'd1);
        end
        if (s == 21) begin
            chk("s1_wrap", 64'(cnt_time), 64'd1);
            chk("s1_tick_off", 64'(win_tick), 64'd0);
            chk("s2_capture_busy", 64'(busy), 64'd1);
        end
        if (s >= 22 && s <= 25) begin
            chk("s2_valid", 64'(rpt_valid), 64'd1);
            chk("s2_idx", 64'(rpt_idx), 64'(s - 22));
            chk("s2_suit", 64'(rpt_suitable), 64'(16 * (s - 22) + 1));
            chk("s2_tot", 64'(rpt_total), 64'(256 * (s - 21)));
            chk("s2_last", 64'(rpt_last), 64'(s == 25));
        end
        if (s == 26) begin
            chk("s2_busy_low", 64'(busy), 64'd0);
            chk("s2_valid_low", 64'(rpt_valid), 64'd0);
        end
        if (s == 40) chk("s1_tick40", 64'(win_tick), 64'd1);
        if (s >= 41 && s <= 59 && rpt_valid && rpt_ready) begin
            chk("s3_suit", 64'(rpt_suitable), 64'('hA0 + nb3));
            chk("s3_tot", 64'(rpt_total), 64'('hB0 + nb3));
            nb3++;
        end
        if (s == 59) chk("s3_beats", 64'(nb3), 64'd4);
        if (s == 81) chk("s4_ovr_set", 64'(overrun), 64'd1);
        if (s == 99) chk("s4_stall_idx", 64'(rpt_idx), 64'd0);
        if (s >= 100 && s <= 110 && rpt_valid && rpt_ready) begin
            chk("s4_suit", 64'(rpt_suitable), 64'('hC0 + nb4));
            chk("s4_tot", 64'(rpt_total), 64'('hD0 + nb4));
            nb4++;
        end
        if (s == 101) chk("s4_set_wins", 64'(overrun), 64'd1);
        if (s == 106) chk("s4_clr", 64'(overrun), 64'd0);
        if (s == 110) chk("s4_beats", 64'(nb4), 64'd4);
        if (s == 137) chk("s5_hold7", 64'(cnt_time), 64'd7);
        if (s == 138) chk("s5_resume8", 64'(cnt_time), 64'd8);
        if (s == 149) chk("s5_no_tick", 64'(win_tick), 64'd0);
        if (s == 150) chk("s5_tick", 64'(win_tick), 64'd1);
        if (s == 174) chk("held_tick", 64'(win_tick), 64'd1);
        if (s == 180) begin
            chk("held_once_ovr", 64'(overrun), 64'd0);
            chk("held_busy", 64'(busy), 64'd1);
        end
        if (s == 217) begin
            chk("s6_pre_ovr", 64'(overrun), 64'd1);
            chk("s6_pre_valid", 64'(rpt_valid), 64'd1);
        end
    endtask

    initial begin
        areset = 1'b1;
        step(); step(); step();
        chk("rst_cnt", 64'(cnt_time), 64'd0);
        chk("rst_valid", 64'(rpt_valid), 64'd0);
        chk("rst_idx", 64'(rpt_idx), 64'd0);
        chk("rst_last", 64'(rpt_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ovr", 64'(overrun), 64'd0);
        chk("rst_suit", 64'(rpt_suitable), 64'd0);
        chk("rst_tot", 64'(rpt_total), 64'd0);

        set_pat(16, 1, 256, 256);
        rpt_ready = 1'b1;
        enable    = 1'b1;
        areset    = 1'b0;
        for (int s = 1; s <= 217; s++) begin
            step();
            drive_step(s);
        end

        // Asynchronous reset in the middle of a stalled drain
        step();
        #2;
        areset = 1'b1;
        #1;
        chk("s6_valid", 64'(rpt_valid), 64'd0);
        chk("s6_busy", 64'(busy), 64'd0);
        chk("s6_cnt", 64'(cnt_time), 64'd0);
        chk("s6_ovr", 64'(overrun), 64'd0);
        chk("s6_suit", 64'(rpt_suitable), 64'd0);
        step(); step();
        set_pat(16, 1, 256, 256);
        rpt_ready = 1'b1;
        enable    = 1'b1;
        areset    = 1'b0;
        for (int s = 1; s <= 30; s++) begin
            step();
            drive_step(s);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
